// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Purpose : Shared types, constants and GF(2^8) arithmetic for the S-box
//           scheduler and its SubByte lanes.
// Revision: 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        DONE_D = 2'd2,
        DONE_K = 2'd3
    } state_t;

    // Job type / last_grant encoding
    localparam logic DATA = 1'b0;
    localparam logic KEY  = 1'b1;

    localparam int AES_STATE_BYTES = 16;
    localparam int AES_WORD_BYTES  = 4;

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (shift-and-add, xtime per bit)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_scheduler_subbyte.sv
`default_nettype none
// ============================================================================
// Module  : sbox_scheduler_subbyte
// Purpose : Combinational AES SubByte: multiplicative inverse in GF(2^8)
//           followed by the AES affine transform.
// Ports   : i_byte - input byte
//           o_byte - substituted byte
// Revision: 1.0 - initial release
// ============================================================================
module sbox_scheduler_subbyte
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Inverse computed as x^254 (maps 0 to 0 naturally) via an addition chain.
    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120;
    logic [7:0] w_x240, w_x252, w_inv;

    assign w_x2   = gf_mul(i_byte, i_byte);
    assign w_x3   = gf_mul(w_x2, i_byte);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign w_x252 = gf_mul(w_x240, w_x12);
    assign w_inv  = gf_mul(w_x252, w_x2);

    // Affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/sbox_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sbox_scheduler
// Purpose : Shares NSBOX SubByte lanes between the round datapath (16-byte
//           state) and the key expansion (4-byte word). Round-robin grant in
//           IDLE, NSBOX bytes substituted per BUSY cycle, result held in
//           DONE_D / DONE_K until the consumer takes it.
// Ports   : clk, reset (async, active high)
//           data_in/_valid/_ready   - state request channel
//           key_in/_valid/_ready    - key word request channel
//           data_out/_valid/_ready  - substituted state channel
//           key_out/_valid/_ready   - substituted word channel
// Revision: 1.0 - initial release
// ============================================================================
module sbox_scheduler
    import aes_pkg::*;
#(
    parameter int NSBOX = 4
)(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] data_in,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    input  logic [31:0]  key_in,
    input  logic         key_in_valid,
    output logic         key_in_ready,
    output logic [127:0] data_out,
    output logic         data_out_valid,
    input  logic         data_out_ready,
    output logic [31:0]  key_out,
    output logic         key_out_valid,
    input  logic         key_out_ready
);

    localparam int C_KD = AES_STATE_BYTES / NSBOX;
    localparam int C_KK = AES_WORD_BYTES / NSBOX;
    localparam int C_CW = $clog2(C_KD);

    generate
        if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4)) begin : g_nsbox_check
            $error("sbox_scheduler: NSBOX must be 1, 2 or 4");
        end
    endgenerate

    state_t             r_state, w_state_nxt;
    logic [C_CW-1:0]    r_cnt;
    logic               r_job;
    logic               r_last;
    logic [127:0]       r_operand;
    logic [127:0]       r_result;

    logic               w_grant_d, w_grant_k;
    logic               w_last_chunk;
    logic [C_CW-1:0]    w_last_cnt;
    logic [7:0]         w_sb_in  [NSBOX];
    logic [7:0]         w_sb_out [NSBOX];
    logic [3:0]         w_idx    [NSBOX];

    // Key wins a tie unless it was the last one granted.
    assign w_grant_k = key_in_valid & (~data_in_valid | (r_last == DATA));
    assign w_grant_d = data_in_valid & ~w_grant_k;

    assign w_last_cnt   = (r_job == KEY) ? C_CW'(C_KK - 1) : C_CW'(C_KD - 1);
    assign w_last_chunk = (r_cnt == w_last_cnt);

    generate
        for (genvar j = 0; j < NSBOX; j++) begin : g_lane
            assign w_idx[j]   = 4'(r_cnt) * 4'(NSBOX) + 4'(j);
            assign w_sb_in[j] = r_operand[{w_idx[j], 3'b000} +: 8];
            sbox_scheduler_subbyte u_subbyte (
                .i_byte (w_sb_in[j]),
                .o_byte (w_sb_out[j])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_job     <= DATA;
            r_last    <= DATA;
            r_operand <= '0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_grant_d || w_grant_k) begin
                        r_cnt     <= '0;
                        r_result  <= '0;
                        r_job     <= w_grant_k ? KEY : DATA;
                        r_last    <= w_grant_k ? KEY : DATA;
                        r_operand <= w_grant_k ? {96'b0, key_in} : data_in;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < NSBOX; j++) begin
                        r_result[{w_idx[j], 3'b000} +: 8] <= w_sb_out[j];
                    end
                    r_cnt <= w_last_chunk ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        data_in_ready  = 1'b0;
        key_in_ready   = 1'b0;
        data_out_valid = 1'b0;
        key_out_valid  = 1'b0;
        data_out       = '0;
        key_out        = '0;
        case (r_state)
            IDLE: begin
                // Ready is forced low while reset is held, even in IDLE.
                data_in_ready = w_grant_d & ~reset;
                key_in_ready  = w_grant_k & ~reset;
                if (w_grant_d || w_grant_k) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_last_chunk) w_state_nxt = (r_job == KEY) ? DONE_K : DONE_D;
            end
            DONE_D: begin
                data_out_valid = 1'b1;
                data_out       = r_result;
                if (data_out_ready) w_state_nxt = IDLE;
            end
            DONE_K: begin
                key_out_valid = 1'b1;
                key_out       = r_result[31:0];
                if (key_out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire
